// File: rtl/pe_pkg.sv
// pe_pkg: shared arbiter state encoding and round-robin pick helper
package pe_pkg;
    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic int rr_pick(input logic [255:0] valid, input int ptr, input int n);
        rr_pick = 0;
        for (int i = n - 1; i >= 0; i--)
            if (valid[(ptr + i) % n]) rr_pick = (ptr + i) % n;
    endfunction
endpackage

// File: rtl/pe_mux.sv
// pe_mux: N-way data select feeding the PE output stage
module pe_mux #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic [WIDTH-1:0]     data_in [(1<<SEL_WIDTH)-1:0],
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [WIDTH-1:0]     data_out
);
    assign data_out = data_in[sel];
endmodule

// File: rtl/pe_mux_arbiter.sv
// pe_mux_arbiter: round-robin burst arbiter sharing one registered PE input among N requesters
module pe_mux_arbiter
    import pe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [(1<<SEL_WIDTH)-1:0] req_valid,
    input  logic [(1<<SEL_WIDTH)-1:0] req_last,
    input  logic [WIDTH-1:0]     req_data [(1<<SEL_WIDTH)-1:0],
    output logic [(1<<SEL_WIDTH)-1:0] req_ready,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 locked,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_src,
    output logic                 out_last
);
    localparam int N  = 1 << SEL_WIDTH;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t           state;
    logic [SEL_WIDTH-1:0] ptr, owner;
    logic [CW-1:0]        beat_cnt;
    logic [WIDTH-1:0]     mux_data;
    logic                 can_load, xfer, rel;

    pe_mux #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_mux (
        .data_in(req_data), .sel(owner), .data_out(mux_data)
    );

    assign locked    = state == ARB_GRANT;
    assign sel       = owner;
    assign can_load  = !out_valid || out_ready;
    assign req_ready = locked && can_load ? N'(1) << owner : '0;
    assign xfer      = locked && can_load && req_valid[owner];
    assign rel       = req_last[owner] || beat_cnt == CW'(MAX_BURST - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == ARB_IDLE) begin
                if (|req_valid) begin
                    owner    <= SEL_WIDTH'(rr_pick(256'(req_valid), int'(ptr), N));
                    beat_cnt <= '0;
                    state    <= ARB_GRANT;
                end
            end else if (xfer) begin
                beat_cnt <= rel ? '0 : beat_cnt + 1'b1;
                if (rel) begin
                    ptr   <= owner + 1'b1;
                    state <= ARB_IDLE;
                end
            end
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_src   <= owner;
                out_last  <= rel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pe_mux_arbiter.sv
// tb_pe_mux_arbiter: directed vectors with hand-computed expectations for pe_mux_arbiter
module tb_pe_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_valid = '0, req_last = '0, req_ready;
    logic [7:0] req_data [7:0];
    logic [2:0] sel, out_src;
    logic       locked, out_valid, out_ready = 1'b1, out_last;
    logic [7:0] out_data;
    int         checks = 0, errors = 0;

    pe_mux_arbiter #(.WIDTH(8), .SEL_WIDTH(3), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .sel(sel), .locked(locked),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) req_data[i] = 8'(i);
        // reset and idle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_state", {out_valid, locked, req_ready, sel, out_src, out_last, out_data}, 0);
        end
        // single burst from requester 2, then ptr=3 arbitration between 1 and 4
        do_reset();
        req_data[2] = 8'h10;
        req_valid = 8'h04;
        tick();
        #1;
        chk("b_lock", locked, 1);
        chk("b_sel", sel, 2);
        chk("b_rdy", req_ready, 8'h04);
        tick();
        chk("b_beat0", {out_valid, out_src, out_last, out_data}, {1'b1, 3'd2, 1'b0, 8'h10});
        req_data[2] = 8'h11;
        tick();
        chk("b_beat1", {out_valid, out_src, out_last, out_data}, {1'b1, 3'd2, 1'b0, 8'h11});
        req_data[2] = 8'h12;
        req_last = 8'h04;
        tick();
        chk("b_beat2", {out_valid, out_src, out_last, out_data}, {1'b1, 3'd2, 1'b1, 8'h12});
        chk("b_unlock", locked, 0);
        req_valid = 8'h12;
        req_last = 8'h12;
        req_data[1] = 8'hB1;
        req_data[4] = 8'hB4;
        tick();
        chk("b_drain", {out_valid, out_data}, {1'b0, 8'h12});
        chk("b_ptr3_pick4", {locked, sel}, {1'b1, 3'd4});
        tick();
        chk("b_beat4", {out_valid, out_src, out_last, out_data}, {1'b1, 3'd4, 1'b1, 8'hB4});
        tick();
        chk("b_wrap_pick1", {locked, sel}, {1'b1, 3'd1});
        req_valid = 8'h02;
        tick();
        chk("b_beat1src", {out_valid, out_src, out_data}, {1'b1, 3'd1, 8'hB1});
        req_valid = '0;
        // burst limit on requester 5
        do_reset();
        req_valid = 8'h20;
        req_data[5] = 8'h55;
        tick();
        begin
            logic [8:0] ev, el;
            ev = 9'b111101111;
            el = 9'b100001000;
            for (int i = 0; i < 9; i++) begin
                tick();
                chk($sformatf("lim_valid%0d", i), out_valid, ev[i]);
                chk($sformatf("lim_lock%0d", i), locked, !el[i]);
                if (ev[i]) chk($sformatf("lim_beat%0d", i), {out_src, out_last, out_data}, {3'd5, el[i], 8'h55});
            end
        end
        req_valid = '0;
        // round robin, all valid with last on every beat
        do_reset();
        for (int i = 0; i < 8; i++) req_data[i] = 8'hA0 + 8'(i);
        req_valid = 8'hFF;
        req_last = 8'hFF;
        tick();
        for (int j = 0; j < 9; j++) begin
            tick();
            chk($sformatf("rr_beat%0d", j), {out_valid, out_src, out_last, out_data},
                {1'b1, 3'(j % 8), 1'b1, 8'hA0 + 8'(j % 8)});
            tick();
            chk($sformatf("rr_gap%0d", j), out_valid, 0);
        end
        req_valid = '0;
        req_last = '0;
        // backpressure mid-burst on requester 3
        do_reset();
        req_valid = 8'h08;
        req_data[3] = 8'h30;
        tick();
        tick();
        chk("bp_beat0", {out_valid, out_src, out_data}, {1'b1, 3'd3, 8'h30});
        req_data[3] = 8'h31;
        out_ready = 1'b0;
        #1;
        chk("bp_rdy0", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), {out_valid, out_src, out_last, out_data, req_ready},
                {1'b1, 3'd3, 1'b0, 8'h30, 8'h00});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy1", req_ready, 8'h08);
        tick();
        chk("bp_beat1", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'h31});
        req_data[3] = 8'h32;
        req_last = 8'h08;
        tick();
        chk("bp_beat2", {out_valid, out_last, out_data}, {1'b1, 1'b1, 8'h32});
        req_valid = '0;
        tick();
        chk("bp_drain", {out_valid, out_data}, {1'b0, 8'h32});
        // wrap priority from ptr=7, then reset mid-burst
        do_reset();
        req_valid = 8'h40;
        req_last = 8'hFF;
        req_data[6] = 8'h66;
        tick();
        tick();
        chk("wr_src6", {out_valid, out_src, out_data}, {1'b1, 3'd6, 8'h66});
        req_valid = 8'h82;
        req_last = '0;
        req_data[7] = 8'h70;
        req_data[1] = 8'h11;
        tick();
        chk("wr_pick7", {locked, sel}, {1'b1, 3'd7});
        tick();
        chk("wr_beat7", {out_valid, out_src, out_data}, {1'b1, 3'd7, 8'h70});
        rst_n = 1'b0;
        #1;
        chk("wr_async_rst", {out_valid, locked, sel, out_data}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("wr_pick1", {locked, sel}, {1'b1, 3'd1});
        req_last = 8'h02;
        tick();
        chk("wr_beat1", {out_valid, out_src, out_last, out_data}, {1'b1, 3'd1, 1'b1, 8'h11});
        req_valid = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_mux_arbiter.md
Name: pe_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one PE datapath input among N = 2^SEL_WIDTH requesters.
- Grants one requester at a time for a burst of beats, with a valid/ready handshake per requester.
- Drives the select of an internal pe_mux instance and registers the selected beat into a single output stage feeding the PE.
- Sits between the PE operand sources (buffers/FIFOs) and the PE compute pipeline.

Parameters:
- WIDTH, 8, data width per requester and per output.
- SEL_WIDTH, 3, select width; N = 2^SEL_WIDTH requesters.
- MAX_BURST, 4, maximum beats per grant before forced release (>=1).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N  per-requester beat valid.
- req_last  input  N  per-requester last-beat-of-burst flag.
- req_data  input  N x WIDTH  per-requester beat data (unpacked array [N-1:0]).
- req_ready  output  N  per-requester accept; one-hot or zero.
- sel  output  SEL_WIDTH  current owner index, also driving the internal pe_mux select.
- locked  output  1  high while a grant is held.
- out_valid  output  1  registered beat valid toward the PE.
- out_ready  input  1  PE accepts the output beat.
- out_data  output  WIDTH  registered beat data.
- out_src  output  SEL_WIDTH  requester index of the registered beat.
- out_last  output  1  beat closed the grant (req_last or burst limit).

Behaviour:
- Reset: clk and rst_n as above; rst_n asserted asynchronously clears every register.
  - state=IDLE, ptr=0, owner=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_src=0, out_last=0.
  - Hence sel=0, locked=0, req_ready=0.
- FSM states:
  - IDLE: req_ready=0. If any req_valid, choose the first asserted index scanning ptr, ptr+1, … with wrap modulo N. Set owner to it, beat_cnt=0, go to GRANT next cycle. With no req_valid, stay in IDLE.
  - GRANT: locked=1, sel=owner.
    - req_ready[owner] = !out_valid || out_ready. All other req_ready bits are 0.
    - A transfer occurs when req_valid[owner] && req_ready[owner].
    - On transfer, load the output stage: out_data=req_data[owner] (via pe_mux), out_src=owner, out_last=release, and beat_cnt++.
    - release = req_last[owner] || (beat_cnt == MAX_BURST-1).
    - On release: ptr = owner+1 (wrap N-1 -> 0), beat_cnt=0, go to IDLE.
    - If the owner drops req_valid mid-burst, the grant is held indefinitely. There is no timeout, and other requesters wait.
- Output stage (one register, no skid):
  - A load with out_valid=0, or with out_valid=1 && out_ready=1, replaces the contents; out_valid=1.
  - out_ready=1 with no load in that cycle: out_valid=0. Data is held, not cleared.
  - out_valid=1 && out_ready=0: all out_* hold, and req_ready=0.
- Latency:
  - A request seen in IDLE at cycle t gives a grant at t+1. The first transfer can occur at t+1, so out_valid is high at t+2.
  - Steady-state throughput within a burst is 1 beat/cycle when out_ready=1.
  - Each grant costs one IDLE arbitration bubble.
- Fairness:
  - ptr advances only on release, to owner+1.
  - With all N requesters continuously valid, grants rotate 0,1,…,N-1,0.
  - A single requester asserting repeatedly still passes through IDLE between grants.
- Boundaries:
  - MAX_BURST=1: every beat releases, out_last=1 on every beat.
  - req_last and the burst limit in the same beat: a single release.
  - ptr=N-1 wraps the scan to index 0.
  - req_valid on non-owners during GRANT is ignored, with no effect on state.
- Reset mid-burst: the in-flight beat in the output register is dropped; arbitration restarts from ptr=0.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits; ptr and owner are SEL_WIDTH bits.

Decomposition:
- Shared package pe_pkg holds:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t.
  - Helper function rr_pick(valid vector, ptr) returning the first set index from ptr with wrap.
- One sub-module: pe_mux (WIDTH, SEL_WIDTH) instantiated with data_in=req_data and sel=owner. Its output feeds the output-register load.

Test Plan:
- Reset/idle: hold rst_n=0 then release with all req_valid=0 -> all outputs 0, locked=0, no req_ready asserted over 20 cycles.
- Single burst: req_valid[2]=1, data 0x10,0x11,0x12 with req_last on the 3rd beat, out_ready=1.
  - Required: locked from cycle 1.
  - out beats 0x10,0x11,0x12 with out_src=2 on consecutive cycles 2–4; out_last only on 0x12.
  - Then ptr=3.
- Burst limit: req_valid[5]=1 held with req_last=0, MAX_BURST=4 -> out_last on the 4th beat, one IDLE bubble, then requester 5 re-granted for the next 4 beats.
- Round-robin: all 8 requesters valid, each with req_last on every beat -> out_src sequence 0,1,2,…,7,0, one beat per two cycles.
- Backpressure: out_ready=0 for 3 cycles mid-burst -> out_valid held with a stable out_data, req_ready[owner]=0; on out_ready=1, no beat is lost or duplicated.
- Wrap/priority plus reset mid-burst:
  - With ptr=7 and requesters 1 and 7 valid -> 7 is granted first, then 1.
  - Assert rst_n=0 during 7's burst -> out_valid drops immediately; after release, requester 1 is granted from ptr=0.
